// File: rtl/mips31_pipe_pkg.sv
// Shared types and encodings for the MIPS31 pipeline control slice.
package mips31_pipe_pkg;

    typedef enum logic {
        RUN,
        STALL
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] WDSEL_LOAD = 2'b01;

endpackage

// File: rtl/hazard_compare.sv
// Combinational source/destination match and stall-need evaluation for the ID stage.
// Need rules depend on HAZARD_FORWARD_EN.
module hazard_compare
    import mips31_pipe_pkg::*;
#(
    parameter logic [1:0] LOAD_SEL = WDSEL_LOAD
) (
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rs_read,
    input  logic       id_rt_read,
    input  logic       exe_we,
    input  logic [4:0] exe_waddr,
    input  logic [1:0] exe_wdata_select,
    input  logic       mem_we,
    input  logic [4:0] mem_waddr,
    output logic       m_exe_rs,
    output logic       m_exe_rt,
    output logic       m_mem_rs,
    output logic       m_mem_rt,
    output logic       exe_is_load,
    output logic [1:0] need
);

    // $0 is hardwired, so a write to it is never a dependency.
    assign m_exe_rs = id_rs_read & exe_we & (exe_waddr == id_rs_addr) & (id_rs_addr != 5'd0);
    assign m_exe_rt = id_rt_read & exe_we & (exe_waddr == id_rt_addr) & (id_rt_addr != 5'd0);
    assign m_mem_rs = id_rs_read & mem_we & (mem_waddr == id_rs_addr) & (id_rs_addr != 5'd0);
    assign m_mem_rt = id_rt_read & mem_we & (mem_waddr == id_rt_addr) & (id_rt_addr != 5'd0);

    assign exe_is_load = (exe_wdata_select == LOAD_SEL);

    always_comb begin
        need = 2'd0;
`ifdef HAZARD_FORWARD_EN
        if ((m_exe_rs | m_exe_rt) & exe_is_load) begin
            need = 2'd1;
        end
`else
        if (m_exe_rs | m_exe_rt) begin
            need = 2'd2;
        end else if (m_mem_rs | m_mem_rt) begin
            need = 2'd1;
        end
`endif
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID/EXE hazard controller: stage enables, bubble insertion, forwarding selects and stall counter.
// Forwarding is built in when HAZARD_FORWARD_EN is defined.
module pipeline_hazard_ctrl
    import mips31_pipe_pkg::*;
#(
    parameter logic [1:0]  LOAD_SEL = WDSEL_LOAD,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_rs_read,
    input  logic             id_rt_read,
    input  logic             exe_GPR_we,
    input  logic [4:0]       exe_GPR_waddr,
    input  logic [1:0]       exe_GPR_wdata_select,
    input  logic             mem_GPR_we,
    input  logic [4:0]       mem_GPR_waddr,
    input  logic             mem_busy,
    output logic             pc_ena,
    output logic             if_id_ena,
    output logic             id_exe_ena,
    output logic             id_exe_bubble,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_cycles
);

    logic       m_exe_rs, m_exe_rt, m_mem_rs, m_mem_rt, exe_is_load;
    logic [1:0] need;

    hazard_compare #(
        .LOAD_SEL(LOAD_SEL)
    ) u_compare (
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rs_read      (id_rs_read),
        .id_rt_read      (id_rt_read),
        .exe_we          (exe_GPR_we),
        .exe_waddr       (exe_GPR_waddr),
        .exe_wdata_select(exe_GPR_wdata_select),
        .mem_we          (mem_GPR_we),
        .mem_waddr       (mem_GPR_waddr),
        .m_exe_rs        (m_exe_rs),
        .m_exe_rt        (m_exe_rt),
        .m_mem_rs        (m_mem_rs),
        .m_mem_rt        (m_mem_rt),
        .exe_is_load     (exe_is_load),
        .need            (need)
    );

    ctrl_state_t      state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    // Clears asynchronously with reset; holds every output quiet until the first edge after release.
    logic             active_q, active_d;
    logic             run_ena, bubble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            cnt_q          <= 2'd0;
            stall_cycles_q <= '0;
            active_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            active_q       <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_ena  = 1'b0;
        bubble   = 1'b0;
        active_d = 1'b1;
        case (state_q)
            RUN: begin
                if (!mem_busy) begin
                    if (need == 2'd0) begin
                        run_ena = 1'b1;
                    end else begin
                        bubble = 1'b1;
                        cnt_d  = need - 2'd1;
                        if (cnt_d != 2'd0) begin
                            state_d = STALL;
                        end
                    end
                end
            end
            STALL: begin
                if (!mem_busy) begin
                    bubble = 1'b1;
                    cnt_d  = cnt_q - 2'd1;
                    if (cnt_d == 2'd0) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (active_q && bubble && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    assign pc_ena        = active_q & run_ena;
    assign if_id_ena     = active_q & run_ena;
    assign id_exe_ena    = active_q & (run_ena | bubble);
    assign id_exe_bubble = active_q & bubble;
    assign stall_cycles  = stall_cycles_q;

`ifdef HAZARD_FORWARD_EN
    // A load result is not ready in EXE; the stall covers it, so the regfile path stays selected.
    always_comb begin
        fwd_rs_sel = FWD_RF;
        fwd_rt_sel = FWD_RF;
        if (active_q) begin
            if (m_exe_rs) begin
                if (!exe_is_load) fwd_rs_sel = FWD_EXE;
            end else if (m_mem_rs) begin
                fwd_rs_sel = FWD_MEM;
            end
            if (m_exe_rt) begin
                if (!exe_is_load) fwd_rt_sel = FWD_EXE;
            end else if (m_mem_rt) begin
                fwd_rt_sel = FWD_MEM;
            end
        end
    end
`else
    logic unused_match;
    assign unused_match = ^{m_exe_rs, m_exe_rt, m_mem_rs, m_mem_rt, exe_is_load};
    assign fwd_rs_sel   = FWD_RF;
    assign fwd_rt_sel   = FWD_RF;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; follows HAZARD_FORWARD_EN like the RTL.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic        id_rs_read, id_rt_read;
    logic        exe_GPR_we;
    logic [4:0]  exe_GPR_waddr;
    logic [1:0]  exe_GPR_wdata_select;
    logic        mem_GPR_we;
    logic [4:0]  mem_GPR_waddr;
    logic        mem_busy;
    logic        pc_ena, if_id_ena, id_exe_ena, id_exe_bubble;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_stall = 0;

    pipeline_hazard_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .id_rs_addr          (id_rs_addr),
        .id_rt_addr          (id_rt_addr),
        .id_rs_read          (id_rs_read),
        .id_rt_read          (id_rt_read),
        .exe_GPR_we          (exe_GPR_we),
        .exe_GPR_waddr       (exe_GPR_waddr),
        .exe_GPR_wdata_select(exe_GPR_wdata_select),
        .mem_GPR_we          (mem_GPR_we),
        .mem_GPR_waddr       (mem_GPR_waddr),
        .mem_busy            (mem_busy),
        .pc_ena              (pc_ena),
        .if_id_ena           (if_id_ena),
        .id_exe_ena          (id_exe_ena),
        .id_exe_bubble       (id_exe_bubble),
        .fwd_rs_sel          (fwd_rs_sel),
        .fwd_rt_sel          (fwd_rt_sel),
        .stall_cycles        (stall_cycles)
    );

    always #5 clk = ~clk;

    // {pc_ena, if_id_ena, id_exe_ena, id_exe_bubble}
    function automatic logic [31:0] en();
        return {28'd0, pc_ena, if_id_ena, id_exe_ena, id_exe_bubble};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic rsr,
                         input logic rtr, input logic ewe, input logic [4:0] ewa,
                         input logic [1:0] esel, input logic mwe, input logic [4:0] mwa,
                         input logic busy);
        id_rs_addr = rs;  id_rt_addr = rt;  id_rs_read = rsr;  id_rt_read = rtr;
        exe_GPR_we = ewe; exe_GPR_waddr = ewa; exe_GPR_wdata_select = esel;
        mem_GPR_we = mwe; mem_GPR_waddr = mwa; mem_busy = busy;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        idle();
        chk("rst_en", en(), 32'h0);
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_fwd_rs", {30'd0, fwd_rs_sel}, 32'd0);
        chk("rst_fwd_rt", {30'd0, fwd_rt_sel}, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("run_en", en(), 32'b1110);

        // Writer to $0 in EXE is never a hazard
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
        chk("r0_en", en(), 32'b1110);
        chk("r0_fwd_rs", {30'd0, fwd_rs_sel}, 32'd0);

`ifdef HAZARD_FORWARD_EN
        // MEM-only match forwards from MEM
        drive(5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b0);
        chk("mem_en", en(), 32'b1110);
        chk("mem_fwd_rt", {30'd0, fwd_rt_sel}, 32'b10);

        // addu $5 in EXE (and stale $5 in MEM): EXE wins, no stall
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 1'b1, 5'd5, 1'b0);
        chk("alu_en", en(), 32'b1110);
        chk("alu_fwd_rt", {30'd0, fwd_rt_sel}, 32'b01);
        step();
        chk("alu_stall", stall_cycles, 32'd0);

        // lw $3 in EXE: one bubble, then forward from MEM
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 2'b01, 1'b0, 5'd0, 1'b0);
        chk("ld_en", en(), 32'b0011);
        chk("ld_fwd_rs", {30'd0, fwd_rs_sel}, 32'd0);
        step();
        exp_stall = exp_stall + 1;
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b0);
        chk("ld_after_en", en(), 32'b1110);
        chk("ld_after_fwd_rs", {30'd0, fwd_rs_sel}, 32'b10);
        chk("ld_stall", stall_cycles, exp_stall);

        // mem_busy overrides a load hazard
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 2'b01, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("busy_en", en(), 32'h0);
            step();
            chk("busy_stall", stall_cycles, exp_stall);
        end
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 2'b01, 1'b0, 5'd0, 1'b0);
        chk("busy_resume_en", en(), 32'b0011);
        step();
        exp_stall = exp_stall + 1;
        idle();
        chk("busy_done_en", en(), 32'b1110);
        chk("busy_done_stall", stall_cycles, exp_stall);

        // Reset asserted during a bubble
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 2'b01, 1'b0, 5'd0, 1'b0);
        chk("pre_rst_en", en(), 32'b0011);
`else
        // MEM-only match: one bubble
        drive(5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b0);
        chk("mem_en", en(), 32'b0011);
        step();
        exp_stall = exp_stall + 1;
        idle();
        chk("mem_after_en", en(), 32'b1110);
        chk("mem_stall", stall_cycles, exp_stall);

        // addu $5 in EXE: two bubbles, then resume
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 1'b0, 5'd0, 1'b0);
        chk("alu_en0", en(), 32'b0011);
        chk("alu_fwd_rt", {30'd0, fwd_rt_sel}, 32'd0);
        step();
        exp_stall = exp_stall + 1;
        chk("alu_en1", en(), 32'b0011);
        chk("alu_stall1", stall_cycles, exp_stall);
        step();
        exp_stall = exp_stall + 1;
        idle();
        chk("alu_after_en", en(), 32'b1110);
        chk("alu_stall2", stall_cycles, exp_stall);

        // lw $3 in EXE also costs two bubbles without forwarding
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 2'b01, 1'b0, 5'd0, 1'b0);
        chk("ld_en0", en(), 32'b0011);
        step();
        chk("ld_en1", en(), 32'b0011);
        step();
        exp_stall = exp_stall + 2;
        idle();
        chk("ld_after_en", en(), 32'b1110);
        chk("ld_stall", stall_cycles, exp_stall);

        // mem_busy for 3 cycles in STALL
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 1'b0, 5'd0, 1'b0);
        step();
        exp_stall = exp_stall + 1;
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("busy_en", en(), 32'h0);
            step();
            chk("busy_stall", stall_cycles, exp_stall);
        end
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 1'b0, 5'd0, 1'b0);
        chk("busy_resume_en", en(), 32'b0011);
        step();
        exp_stall = exp_stall + 1;
        idle();
        chk("busy_done_en", en(), 32'b1110);
        chk("busy_done_stall", stall_cycles, exp_stall);

        // Enter STALL with cnt=1, then assert reset
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 1'b0, 5'd0, 1'b0);
        step();
        chk("pre_rst_en", en(), 32'b0011);
`endif
        reset = 1'b0;
        #1;
        chk("midrst_en", en(), 32'h0);
        chk("midrst_stall", stall_cycles, 32'd0);
        step();
        idle();
        reset = 1'b1;
        step();
        chk("postrst_en", en(), 32'b1110);
        chk("postrst_stall", stall_cycles, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
